// File: rtl/kmap_sweep_ctrl.sv
// Sweeps every input vector through an SOP and a POS K-map implementation,
// captures both truth tables and reports the first and total disagreements.
module kmap_sweep_ctrl #(
   parameter int NVARS  = 4,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [NVARS-1:0]      x,
   input  logic                  sop_in,
   input  logic                  pos_in,
   output logic                  busy,
   output logic                  done,
   output logic [2**NVARS-1:0]   truth_sop,
   output logic [2**NVARS-1:0]   truth_pos,
   output logic                  mismatch,
   output logic [NVARS-1:0]      mm_idx,
   output logic [NVARS:0]        mm_count,
   output logic [2:0]            state_dbg
);

   localparam int NV = 2**NVARS;
   localparam logic [NVARS-1:0] LAST_IDX = NVARS'(NV - 1);
   localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_WAIT   = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [NVARS-1:0]    idx_q, idx_d;
   logic [NVARS-1:0]    x_q, x_d;
   logic [3:0]          wait_q, wait_d;
   logic [NV-1:0]       tsop_q, tsop_d;
   logic [NV-1:0]       tpos_q, tpos_d;
   logic                mm_q, mm_d;
   logic [NVARS-1:0]    mm_idx_q, mm_idx_d;
   logic [NVARS:0]      mm_cnt_q, mm_cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         x_q      <= '0;
         wait_q   <= '0;
         tsop_q   <= '0;
         tpos_q   <= '0;
         mm_q     <= 1'b0;
         mm_idx_q <= '0;
         mm_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         x_q      <= x_d;
         wait_q   <= wait_d;
         tsop_q   <= tsop_d;
         tpos_q   <= tpos_d;
         mm_q     <= mm_d;
         mm_idx_q <= mm_idx_d;
         mm_cnt_q <= mm_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      x_d      = x_q;
      wait_d   = wait_q;
      tsop_d   = tsop_q;
      tpos_d   = tpos_q;
      mm_d     = mm_q;
      mm_idx_d = mm_idx_q;
      mm_cnt_d = mm_cnt_q;
      case (state_q)
         S_IDLE: begin
            // Previous results stay visible until a new sweep actually starts.
            if (start) begin
               state_d  = S_APPLY;
               idx_d    = '0;
               tsop_d   = '0;
               tpos_d   = '0;
               mm_d     = 1'b0;
               mm_idx_d = '0;
               mm_cnt_d = '0;
            end
         end
         S_APPLY: begin
            x_d     = idx_q;
            wait_d  = '0;
            state_d = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
         end
         S_WAIT: begin
            if (wait_q == SETTLE_LAST) state_d = S_SAMPLE;
            else                       wait_d  = wait_q + 4'd1;
         end
         S_SAMPLE: begin
            tsop_d[idx_q] = sop_in;
            tpos_d[idx_q] = pos_in;
            if (sop_in != pos_in) begin
               mm_cnt_d = mm_cnt_q + 1'b1;
               if (!mm_q) mm_idx_d = idx_q;
               mm_d = 1'b1;
            end
            // Terminate by compare so idx never wraps.
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_APPLY;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign x         = x_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign truth_sop = tsop_q;
   assign truth_pos = tpos_q;
   assign mismatch  = mm_q;
   assign mm_idx    = mm_idx_q;
   assign mm_count  = mm_cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Bench for kmap_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0) sweep the same
// function; a reference model predicts each sweep and a monitor checks on done.
module tb_kmap_sweep_ctrl;

   localparam int N  = 4;
   localparam int S0 = 0;
   localparam int S1 = 1;

   typedef struct packed {
      logic [15:0] tsop;
      logic [15:0] tpos;
      logic        mm;
      logic [3:0]  mmi;
      logic [4:0]  mmc;
      logic [31:0] start_cyc;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  x     [2];
   logic        sop_in[2];
   logic        pos_in[2];
   logic        busy  [2];
   logic        done  [2];
   logic [15:0] ts    [2];
   logic [15:0] tp    [2];
   logic        mm    [2];
   logic [3:0]  mmi   [2];
   logic [4:0]  mmc   [2];
   logic [2:0]  st    [2];

   logic [15:0] sop_tt = '0;
   logic [15:0] pos_tt = '0;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          tmo_req = 0;
   int          tmo_seen = 0;
   bit          end_req = 1'b0;
   bit          end_ack = 1'b0;

   rec_t exp_q0[$];
   rec_t exp_q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Both K-map blocks are combinational lookups of the bench's truth tables.
   assign sop_in[0] = sop_tt[x[0]];
   assign pos_in[0] = pos_tt[x[0]];
   assign sop_in[1] = sop_tt[x[1]];
   assign pos_in[1] = pos_tt[x[1]];

   kmap_sweep_ctrl #(.NVARS(N), .SETTLE(S0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .x(x[0]),
      .sop_in(sop_in[0]), .pos_in(pos_in[0]), .busy(busy[0]), .done(done[0]),
      .truth_sop(ts[0]), .truth_pos(tp[0]), .mismatch(mm[0]), .mm_idx(mmi[0]),
      .mm_count(mmc[0]), .state_dbg(st[0])
   );

   kmap_sweep_ctrl #(.NVARS(N), .SETTLE(S1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .x(x[1]),
      .sop_in(sop_in[1]), .pos_in(pos_in[1]), .busy(busy[1]), .done(done[1]),
      .truth_sop(ts[1]), .truth_pos(tp[1]), .mismatch(mm[1]), .mm_idx(mmi[1]),
      .mm_count(mmc[1]), .state_dbg(st[1])
   );

   // Reference: scan all minterms, compare, count; latency from the sweep formula.
   function automatic rec_t model(input logic [15:0] s, input logic [15:0] p,
                                  input int unsigned sc);
      rec_t r;
      r = '0;
      r.start_cyc = sc;
      r.tsop = s;
      r.tpos = p;
      for (int i = 0; i < 16; i++) begin
         if (s[i] != p[i]) begin
            if (r.mmc == 0) r.mmi = 4'(i);
            r.mmc = r.mmc + 5'd1;
         end
      end
      r.mm = (r.mmc != 0);
      return r;
   endfunction

   function automatic int exp_lat(input int d);
      return (2**N) * (((d == 0) ? S0 : S1) + 2) + 1;
   endfunction

   task automatic chk(input string nm, input int d, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h want %0h (t=%0t)", nm, d, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit   rst_prev = 1'b0;
   bit   busy_prev[2] = '{1'b0, 1'b0};
   bit   done_prev[2] = '{1'b0, 1'b0};
   bit   held_ok[2]   = '{1'b0, 1'b0};
   int   busy_cnt[2]  = '{0, 0};
   rec_t held[2];

   always @(negedge clk) begin
      rec_t r;
      bit   have;
      for (int d = 0; d < 2; d++) begin
         if (rst_prev && !reset) begin
            chk("reset_outputs", d,
                64'({x[d], busy[d], done[d], ts[d], tp[d], mm[d], mmi[d], mmc[d]}), 64'd0);
         end
         if (reset) begin
            busy_cnt[d]  = 0;
            busy_prev[d] = 1'b0;
            done_prev[d] = 1'b0;
            held_ok[d]   = 1'b0;
         end else begin
            if (done[d]) begin
               chk("done_width", d, 64'(done_prev[d]), 64'd0);
               have = 1'b0;
               r = '0;
               if (d == 0) begin
                  if (exp_q0.size() > 0) begin have = 1'b1; r = exp_q0.pop_front(); end
               end else begin
                  if (exp_q1.size() > 0) begin have = 1'b1; r = exp_q1.pop_front(); end
               end
               chk("done_expected", d, 64'(have), 64'd1);
               if (have) begin
                  chk("truth_sop", d, 64'(ts[d]), 64'(r.tsop));
                  chk("truth_pos", d, 64'(tp[d]), 64'(r.tpos));
                  chk("mismatch", d, 64'(mm[d]), 64'(r.mm));
                  chk("mm_idx", d, 64'(mmi[d]), 64'(r.mmi));
                  chk("mm_count", d, 64'(mmc[d]), 64'(r.mmc));
                  chk("latency", d, 64'(cyc - r.start_cyc), 64'(exp_lat(d)));
                  chk("busy_at_done", d, 64'(busy[d]), 64'd1);
                  held[d]    = r;
                  held_ok[d] = 1'b1;
               end
            end
            if (busy[d]) begin
               busy_cnt[d]++;
            end else begin
               if (busy_prev[d]) chk("busy_length", d, 64'(busy_cnt[d]), 64'(exp_lat(d)));
               busy_cnt[d] = 0;
               if (held_ok[d]) begin
                  chk("held_sop", d, 64'(ts[d]), 64'(held[d].tsop));
                  chk("held_mmc", d, 64'(mmc[d]), 64'(held[d].mmc));
               end
            end
            busy_prev[d] = busy[d];
            done_prev[d] = done[d];
         end
      end
      rst_prev = reset;
      if (tmo_req != tmo_seen) begin
         chk("wait_timeout", 0, 64'(tmo_seen), 64'(tmo_req));
         tmo_seen = tmo_req;
      end
      if (end_req && !end_ack) begin
         chk("queue_drained", 0, 64'(exp_q0.size()), 64'd0);
         chk("queue_drained", 1, 64'(exp_q1.size()), 64'd0);
         end_ack = 1'b1;
      end
   end

   // ---------------- driver ----------------
   task automatic issue_start();
      rec_t r;
      @(negedge clk);
      start = 1'b1;
      r = model(sop_tt, pos_tt, cyc);
      exp_q0.push_back(r);
      exp_q1.push_back(r);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy[0] || busy[1]) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy[0] || busy[1]) tmo_req++;
   endtask

   task automatic pulse_reset(input bit with_start);
      @(negedge clk);
      reset = 1'b1;
      start = with_start;
      exp_q0.delete();
      exp_q1.delete();
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
   endtask

   task automatic sweep(input logic [15:0] s, input logic [15:0] p);
      sop_tt = s;
      pos_tt = p;
      issue_start();
      wait_idle();
      repeat ($urandom_range(1, 4)) @(negedge clk);
   endtask

   initial begin
      logic [15:0] f;
      logic [15:0] mask;
      int          minterms[7] = '{0, 1, 2, 4, 6, 12, 14};
      f = '0;
      foreach (minterms[i]) f[minterms[i]] = 1'b1;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      sweep(f, f);
      sweep(f, ~f);
      sweep(f, f ^ 16'h2200);

      // start re-asserted while busy must be ignored.
      sop_tt = f;
      pos_tt = f;
      issue_start();
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      // Reset mid-sweep, then a full sweep must still be correct.
      sop_tt = 16'($urandom);
      pos_tt = sop_tt ^ 16'h0081;
      issue_start();
      repeat (28) @(negedge clk);
      pulse_reset(1'b0);
      repeat (2) @(negedge clk);
      sweep(sop_tt, pos_tt);

      // start coincident with reset: reset wins.
      pulse_reset(1'b1);
      repeat (3) @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         case ($urandom_range(0, 3))
            0:       mask = 16'h0000;
            1:       mask = 16'hFFFF;
            2:       mask = 16'(1 << $urandom_range(0, 15));
            default: mask = 16'($urandom);
         endcase
         f = 16'($urandom);
         sweep(f, f ^ mask);
      end

      end_req = 1'b1;
      for (int n = 0; n < 10 && !end_ack; n++) @(negedge clk);
      if (!end_ack) begin
         errors++;
         $display("FAIL end_handshake: got no ack want ack");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
